// File: rtl/int2float_pipe_if.sv
// Handshake bundle for the pipelined integer-to-float converter.
// master drives operands and consumes results; slave is the converter.
interface int2float_pipe_if #(
   parameter int IN_W = 32
) ();
   logic            in_valid;
   logic            in_ready;
   logic [IN_W-1:0] in_data;
   logic            in_signed;
   logic [1:0]      in_rm;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_data;
   logic            out_inexact;

   modport master (
      output in_valid, in_data, in_signed, in_rm, out_ready,
      input  in_ready, out_valid, out_data, out_inexact
   );

   modport slave (
      input  in_valid, in_data, in_signed, in_rm, out_ready,
      output in_ready, out_valid, out_data, out_inexact
   );
endinterface

// File: rtl/int2float_pipe.sv
// Three-stage integer to IEEE-754 single-precision converter.
// S1 takes the magnitude, S2 normalises with a log shifter, S3 rounds and packs.
// A stalled output freezes every stage; bubbles advance with the pipeline.
module int2float_pipe #(
   parameter int IN_W = 32
) (
   input logic            clk,
   input logic            rst,
   int2float_pipe_if.slave bus
);
   localparam int unsigned LzW    = $clog2(IN_W) + 1;
   localparam int unsigned Levels = $clog2(IN_W);
   localparam int unsigned NormW  = (IN_W > 26) ? IN_W : 26;
   localparam logic [7:0]  ExpTop = 8'(127 + IN_W - 1);

   logic stall;

   logic            s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d, s1_zero_q, s1_zero_d;
   logic [IN_W-1:0] s1_mag_q, s1_mag_d;
   logic [1:0]      s1_rm_q, s1_rm_d;

   logic            s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d, s2_zero_q, s2_zero_d;
   logic [IN_W-1:0] s2_norm_q, s2_norm_d;
   logic [7:0]      s2_exp_q, s2_exp_d;
   logic [1:0]      s2_rm_q, s2_rm_d;

   logic            out_valid_q, out_valid_d, out_inexact_q, out_inexact_d;
   logic [31:0]     out_data_q, out_data_d;

   assign stall           = out_valid_q & ~bus.out_ready;
   assign bus.in_ready    = ~stall;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;
   assign bus.out_inexact = out_inexact_q;

   // S1: capture sign and magnitude of an accepted operand
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_sign_d  = s1_sign_q;
      s1_zero_d  = s1_zero_q;
      s1_mag_d   = s1_mag_q;
      s1_rm_d    = s1_rm_q;
      if (!stall) begin
         s1_valid_d = bus.in_valid;
         if (bus.in_valid) begin
            s1_sign_d = bus.in_signed & bus.in_data[IN_W-1];
            // most-negative input yields 2^(IN_W-1), correct as unsigned
            s1_mag_d  = s1_sign_d ? ('0 - bus.in_data) : bus.in_data;
            s1_zero_d = (bus.in_data == '0);
            s1_rm_d   = bus.in_rm;
         end
      end
   end

   logic [IN_W-1:0] lz_norm;
   logic [LzW-1:0]  lz_cnt;

   // Leading-zero count and normalise in one pass, largest shift step first
   always_comb begin
      lz_norm = s1_mag_q;
      lz_cnt  = '0;
      for (int k = Levels - 1; k >= 0; k--) begin
         if ((lz_norm >> (IN_W - (1 << k))) == '0) begin
            lz_norm = lz_norm << (1 << k);
            lz_cnt  = lz_cnt + LzW'(1 << k);
         end
      end
   end

   // S2: register normalised mantissa and biased exponent
   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_sign_d  = s2_sign_q;
      s2_zero_d  = s2_zero_q;
      s2_norm_d  = s2_norm_q;
      s2_exp_d   = s2_exp_q;
      s2_rm_d    = s2_rm_q;
      if (!stall) begin
         s2_valid_d = s1_valid_q;
         s2_sign_d  = s1_sign_q;
         s2_zero_d  = s1_zero_q;
         s2_norm_d  = lz_norm;
         s2_exp_d   = ExpTop - 8'(lz_cnt);
         s2_rm_d    = s1_rm_q;
      end
   end

   logic [NormW-1:0] ext;
   logic [23:0]      rnd_m;
   logic             rnd_g, rnd_s, rnd_inc;
   logic [24:0]      rnd_mr;
   logic [7:0]       pk_exp;
   logic [22:0]      pk_frac;
   logic [31:0]      pk_data;
   logic             pk_inexact;
   logic             unused_mr23;

   assign unused_mr23 = rnd_mr[23];

   // S3 datapath: guard/sticky extraction, rounding increment, carry into exponent
   always_comb begin
      ext   = NormW'(s2_norm_q) << (NormW - IN_W);
      rnd_m = ext[NormW-1 -: 24];
      rnd_g = ext[NormW-25];
      rnd_s = |ext[NormW-26:0];
      case (s2_rm_q)
         2'b00:   rnd_inc = rnd_g & (rnd_s | rnd_m[0]);
         2'b01:   rnd_inc = 1'b0;
         2'b10:   rnd_inc = ~s2_sign_q & (rnd_g | rnd_s);
         default: rnd_inc = s2_sign_q & (rnd_g | rnd_s);
      endcase
      rnd_mr = {1'b0, rnd_m} + {24'd0, rnd_inc};
      if (rnd_mr[24]) begin
         pk_frac = '0;
         pk_exp  = s2_exp_q + 8'd1;
      end else begin
         pk_frac = rnd_mr[22:0];
         pk_exp  = s2_exp_q;
      end
      pk_data    = s2_zero_q ? 32'h0000_0000 : {s2_sign_q, pk_exp, pk_frac};
      pk_inexact = ~s2_zero_q & (rnd_g | rnd_s);
   end

   // S3: output register; bubbles load zero so idle outputs stay clean
   always_comb begin
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_inexact_d = out_inexact_q;
      if (!stall) begin
         out_valid_d   = s2_valid_q;
         out_data_d    = s2_valid_q ? pk_data : 32'h0;
         out_inexact_d = s2_valid_q & pk_inexact;
      end
   end

   // Pipeline state; synchronous reset drops all in-flight operations
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q    <= 1'b0;
         s1_sign_q     <= 1'b0;
         s1_zero_q     <= 1'b0;
         s1_mag_q      <= '0;
         s1_rm_q       <= 2'b00;
         s2_valid_q    <= 1'b0;
         s2_sign_q     <= 1'b0;
         s2_zero_q     <= 1'b0;
         s2_norm_q     <= '0;
         s2_exp_q      <= 8'd0;
         s2_rm_q       <= 2'b00;
         out_valid_q   <= 1'b0;
         out_data_q    <= 32'h0;
         out_inexact_q <= 1'b0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         s1_sign_q     <= s1_sign_d;
         s1_zero_q     <= s1_zero_d;
         s1_mag_q      <= s1_mag_d;
         s1_rm_q       <= s1_rm_d;
         s2_valid_q    <= s2_valid_d;
         s2_sign_q     <= s2_sign_d;
         s2_zero_q     <= s2_zero_d;
         s2_norm_q     <= s2_norm_d;
         s2_exp_q      <= s2_exp_d;
         s2_rm_q       <= s2_rm_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_inexact_q <= out_inexact_d;
      end
   end
endmodule

// File: tb/tb_int2float_pipe.sv
// Directed bench for int2float_pipe at IN_W = 32, 16 and 64.
module tb_int2float_pipe;
   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   int2float_pipe_if #(.IN_W(32)) b32 ();
   int2float_pipe_if #(.IN_W(16)) b16 ();
   int2float_pipe_if #(.IN_W(64)) b64 ();

   int2float_pipe #(.IN_W(32)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));
   int2float_pipe #(.IN_W(16)) u16 (.clk(clk), .rst(rst), .bus(b16.slave));
   int2float_pipe #(.IN_W(64)) u64 (.clk(clk), .rst(rst), .bus(b64.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sample(input int w, output logic v, output logic [31:0] d, output logic i);
      case (w)
         16:      begin v = b16.out_valid; d = b16.out_data; i = b16.out_inexact; end
         64:      begin v = b64.out_valid; d = b64.out_data; i = b64.out_inexact; end
         default: begin v = b32.out_valid; d = b32.out_data; i = b32.out_inexact; end
      endcase
   endtask

   // One operand through the chosen instance; checks latency, result and inexact
   task automatic conv(input int w, input logic [63:0] d, input logic sg, input logic [1:0] rm,
                       input logic [31:0] ed, input logic ei, input string tag);
      int          n;
      logic        v, oi;
      logic [31:0] od;
      case (w)
         16: begin
            b16.in_valid = 1'b1; b16.in_data = d[15:0]; b16.in_signed = sg; b16.in_rm = rm;
         end
         64: begin
            b64.in_valid = 1'b1; b64.in_data = d; b64.in_signed = sg; b64.in_rm = rm;
         end
         default: begin
            b32.in_valid = 1'b1; b32.in_data = d[31:0]; b32.in_signed = sg; b32.in_rm = rm;
         end
      endcase
      tick();
      b16.in_valid = 1'b0;
      b32.in_valid = 1'b0;
      b64.in_valid = 1'b0;
      n = 1;
      sample(w, v, od, oi);
      while (!v && n < 10) begin
         tick();
         n++;
         sample(w, v, od, oi);
      end
      chk({tag, "_lat"}, 64'(n), 64'd3);
      chk({tag, "_data"}, {32'h0, od}, {32'h0, ed});
      chk({tag, "_inex"}, {63'h0, oi}, {63'h0, ei});
      tick();
   endtask

   logic [31:0] st_in  [4] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000};
   logic [31:0] st_exp [4] = '{32'h0, 32'h3F80_0000, 32'hBF80_0000, 32'hCF00_0000};
   logic [31:0] bp_exp [5] = '{32'h4120_0000, 32'h4130_0000, 32'h4140_0000,
                               32'h4150_0000, 32'h4160_0000};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int          sent, rcv;
      logic        acc, held_vld;
      logic [31:0] held;

      rst = 1'b1;
      b32.in_valid = 1'b0; b32.in_data = '0; b32.in_signed = 1'b0; b32.in_rm = 2'b00;
      b16.in_valid = 1'b0; b16.in_data = '0; b16.in_signed = 1'b0; b16.in_rm = 2'b00;
      b64.in_valid = 1'b0; b64.in_data = '0; b64.in_signed = 1'b0; b64.in_rm = 2'b00;
      b32.out_ready = 1'b1;
      b16.out_ready = 1'b1;
      b64.out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("rst_out_valid", {63'h0, b32.out_valid}, 64'h0);
      chk("rst_out_data", {32'h0, b32.out_data}, 64'h0);
      chk("rst_inexact", {63'h0, b32.out_inexact}, 64'h0);
      chk("rst_in_ready", {63'h0, b32.in_ready}, 64'h1);

      // Back-to-back signed RNE stream, results three cycles after each acceptance
      for (int i = 0; i < 6; i++) begin
         if (i < 4) begin
            b32.in_valid = 1'b1; b32.in_data = st_in[i]; b32.in_signed = 1'b1; b32.in_rm = 2'b00;
         end else begin
            b32.in_valid = 1'b0;
         end
         tick();
         if (i >= 2) begin
            chk("stream_valid", {63'h0, b32.out_valid}, 64'h1);
            chk("stream_data", {32'h0, b32.out_data}, {32'h0, st_exp[i-2]});
            chk("stream_inex", {63'h0, b32.out_inexact}, 64'h0);
         end else begin
            chk("stream_bubble", {63'h0, b32.out_valid}, 64'h0);
         end
      end
      tick();

      // Rounding at the tie point and mantissa carry
      conv(32, 64'h0100_0001, 1'b0, 2'b00, 32'h4B80_0000, 1'b1, "rne_tie");
      conv(32, 64'h0100_0001, 1'b0, 2'b01, 32'h4B80_0000, 1'b1, "rz_tie");
      conv(32, 64'h0100_0001, 1'b0, 2'b10, 32'h4B80_0001, 1'b1, "rup_tie");
      conv(32, 64'hFEFF_FFFF, 1'b1, 2'b11, 32'hCB80_0001, 1'b1, "rdn_neg");
      conv(32, 64'hFEFF_FFFF, 1'b1, 2'b10, 32'hCB80_0000, 1'b1, "rup_neg");
      conv(32, 64'h7FFF_FFFF, 1'b1, 2'b00, 32'h4F00_0000, 1'b1, "carry_rne");
      conv(32, 64'h7FFF_FFFF, 1'b1, 2'b01, 32'h4EFF_FFFF, 1'b1, "carry_rz");
      conv(32, 64'hFFFF_FFFF, 1'b0, 2'b00, 32'h4F80_0000, 1'b1, "umax_rne");
      conv(32, 64'h0, 1'b1, 2'b11, 32'h0, 1'b0, "zero_rdn");

      // Other widths
      conv(16, 64'h8000, 1'b1, 2'b00, 32'hC700_0000, 1'b0, "w16_min");
      conv(16, 64'h7FFF, 1'b1, 2'b00, 32'h46FF_FE00, 1'b0, "w16_max");
      conv(64, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'b01, 32'h5F7F_FFFF, 1'b1, "w64_rz");

      // Backpressure: consumer idle for cycles 4..8 of a 5-operand stream
      sent = 0;
      rcv = 0;
      held = '0;
      held_vld = 1'b0;
      for (int c = 0; c < 40; c++) begin
         b32.out_ready = !(c >= 4 && c <= 8);
         b32.in_valid = (sent < 5);
         b32.in_data = 32'(10 + sent);
         b32.in_signed = 1'b0;
         b32.in_rm = 2'b00;
         #1;
         if (b32.out_valid && !b32.out_ready) begin
            chk("bp_in_ready", {63'h0, b32.in_ready}, 64'h0);
            if (held_vld) chk("bp_hold", {32'h0, b32.out_data}, {32'h0, held});
            held = b32.out_data;
            held_vld = 1'b1;
         end else begin
            held_vld = 1'b0;
         end
         if (b32.out_valid && b32.out_ready) begin
            if (rcv < 5) chk("bp_data", {32'h0, b32.out_data}, {32'h0, bp_exp[rcv]});
            rcv++;
         end
         acc = b32.in_valid & b32.in_ready;
         tick();
         if (acc) sent++;
      end
      b32.in_valid = 1'b0;
      b32.out_ready = 1'b1;
      chk("bp_sent", 64'(sent), 64'd5);
      chk("bp_count", 64'(rcv), 64'd5);

      // Reset with three operands in flight and the output stalled
      b32.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         b32.in_valid = 1'b1; b32.in_data = 32'(i + 1); b32.in_signed = 1'b0; b32.in_rm = 2'b00;
         tick();
      end
      b32.in_valid = 1'b0;
      chk("mid_full", {63'h0, b32.out_valid}, 64'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_valid", {63'h0, b32.out_valid}, 64'h0);
      chk("mid_rst_data", {32'h0, b32.out_data}, 64'h0);
      b32.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("mid_no_stale", {63'h0, b32.out_valid}, 64'h0);
      end
      conv(32, 64'h5, 1'b0, 2'b00, 32'h40A0_0000, 1'b0, "post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/int2float_pipe.md
Name: int2float_pipe

Overview:
- Parametrised, 3-stage pipelined integer-to-IEEE-754 single-precision converter for the pipelined FPU datapath.
- Generalises the combinational integer-to-float converter:
  - configurable input width
  - per-operation signed/unsigned mode
  - four IEEE rounding modes with correct mantissa-carry handling
  - inexact flag
  - valid/ready handshake with full-pipeline stall

Parameters:
- IN_W, 32, integer input width; legal range 8..64.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operand valid
- in_ready  output  1  converter can accept operand this cycle
- in_data  input  IN_W  integer operand
- in_signed  input  1  1 = two's-complement, 0 = unsigned
- in_rm  input  2  rounding mode:
  - 00 RNE (round to nearest even)
  - 01 RZ (toward zero)
  - 10 RUP (toward +inf)
  - 11 RDN (toward -inf)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  32  single-precision result
- out_inexact  output  1  result not exactly equal to operand (precision lost)

Behaviour:
- Reset:
  - Synchronous, active-high.
  - Clears all stage valid bits; out_valid=0, out_data=0, out_inexact=0.
  - in_ready=1 in the cycle after reset deasserts.
  - Reset mid-operation discards all in-flight operations; nothing is emitted for them.
- Stall rule:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - When stall=1, every stage register holds its value.
  - When stall=0, all stages advance one step; bubbles advance too and are not collapsed.
- Transfers:
  - Input accepted when in_valid & in_ready.
  - Output consumed when out_valid & out_ready.
- Latency: exactly 3 cycles from acceptance to out_valid with no stall. Throughput is 1 per cycle.
- Stage 1 (S1): capture operand.
  - sign = in_signed & in_data[IN_W-1].
  - mag = sign ? (0 - in_data) : in_data, IN_W bits unsigned.
  - The most-negative value -2^(IN_W-1) gives mag = 2^(IN_W-1), which is correct as unsigned.
  - zero = (in_data == 0).
  - Also registers rm and a valid bit.
- Stage 2 (S2): normalise.
  - lz = leading-zero count of mag, using a log-shifter (shift by 2^k steps, k descending).
  - norm = mag << lz, so norm[IN_W-1] = 1 for nonzero operands.
  - e = 127 + (IN_W-1 - lz).
  - Registers sign, zero, rm, valid.
- Stage 3 (S3): round and pack.
  - Extend norm to at least 26 bits by zero-padding on the right.
  - m = top 24 bits, g = next bit, s = OR of all remaining bits.
  - Increment decision:
    - RNE: inc = g & (s | m[0])
    - RZ: inc = 0
    - RUP: inc = ~sign & (g|s)
    - RDN: inc = sign & (g|s)
  - mr = m + inc, 25 bits.
  - If mr[24]=1 (carry out): fraction = 0 and exponent e+1. Otherwise fraction = mr[22:0] and exponent e.
  - Exponent never exceeds 127+64, so no overflow or infinity case exists.
  - out_data = zero ? 32'h00000000 : {sign, exponent[7:0], fraction}.
  - out_inexact = ~zero & (g|s).
  - For IN_W <= 24, out_inexact is always 0.
- Zero always yields +0, never -0, in every rounding mode.
- in_signed and in_rm are sampled per operation; mixing modes back-to-back is legal.
- in_data, in_signed and in_rm are ignored when in_valid=0 or in_ready=0.
- out_data and out_inexact hold stable while out_valid & ~out_ready.

Test Plan:
- Basic signed conversion, IN_W=32, signed, RNE, inputs 0, 1, 0xFFFFFFFF, 0x80000000 on consecutive cycles, out_ready=1:
  - Outputs on cycles 3..6 are 0x00000000, 0x3F800000, 0xBF800000, 0xCF000000.
  - All have inexact=0.
- Rounding modes at the tie point, input 0x01000001 unsigned:
  - RNE gives 0x4B800000, inexact=1.
  - RZ gives 0x4B800000.
  - RUP gives 0x4B800001.
  - Signed input 0xFEFFFFFF with RDN gives 0xCB800001, and with RUP gives 0xCB800000.
- Mantissa carry:
  - 0x7FFFFFFF signed RNE gives 0x4F000000, inexact=1.
  - 0x7FFFFFFF signed RZ gives 0x4EFFFFFF.
  - 0xFFFFFFFF unsigned RNE gives 0x4F800000, inexact=1.
- Backpressure:
  - Stream 5 operands with out_ready held 0 from cycle 4 to cycle 8.
  - in_ready=0 while stalled; out_data remains constant.
  - All 5 results emerge in order with none lost or duplicated.
- Reset mid-stream:
  - Assert rst for 1 cycle with 3 operands in flight.
  - out_valid=0 the next cycle, and no stale results appear afterwards.
  - The next accepted operand emerges 3 cycles after acceptance.
- Parameter sweep:
  - IN_W=16 signed: 0x8000 gives 0xC7000000, and 0x7FFF gives 0x46FFFE00 with inexact=0.
  - IN_W=64 unsigned: 2^64-1 with RZ gives 0x5F7FFFFF, inexact=1.
